// File: rtl/store_pkg.sv
// Shared types for the store commit buffer: funct3 store-width codes, the queued
// entry layout and the drain FSM states.
package store_pkg;

  localparam logic [2:0] W_SB = 3'b000;
  localparam logic [2:0] W_SH = 3'b001;
  localparam logic [2:0] W_SW = 3'b010;

  typedef struct packed {
    logic [29:0] addr_word;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/store_fifo.sv
// DEPTH-entry circular queue of formatted stores; push visible at the next edge,
// head is combinational. Exposes every slot plus a valid mask for load hazard lookups.
module store_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  store_entry_t             i_dat,
  input  logic                     i_pop,
  output store_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output store_entry_t             o_entries [DEPTH],
  output logic [DEPTH-1:0]         o_valid
);

  localparam int PW = $clog2(DEPTH);

  store_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers are exactly PW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_comb begin
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off        = PW'(i) - r_rd_ptr;
      o_valid[i] = ({1'b0, off} < r_count);
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_entries = r_mem;

endmodule

// File: rtl/store_commit_buffer.sv
// Commit-order store buffer; a store enters mem_req two edges after commit, drains at most one per 2 cycles.
// commit_ready drops only when full; define STORE_FWD_HAZARD_EN for exact word-match ld_hit.
module store_commit_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   commit_valid,
  input  logic [2:0]             commit_width,
  input  logic [31:0]            commit_addr,
  input  logic [31:0]            commit_data,
  output logic                   commit_ready,
  output logic                   misalign_err,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wstrb,
  input  logic                   mem_ack,
  input  logic [31:0]            ld_addr,
  output logic                   ld_hit,
  output logic [$clog2(DEPTH):0] count
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_misalign_err;
  logic                   w_take;
  logic                   w_legal;
  logic [31:0]            w_wdata;
  logic [3:0]             w_wstrb;
  store_entry_t           w_entry;
  store_entry_t           w_head;
  store_entry_t           w_entries [DEPTH];
  logic [DEPTH-1:0]       w_valid;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_mem_req;

  assign commit_ready = ~w_full;
  assign w_take       = commit_valid & commit_ready;

  always_comb begin
    w_legal = 1'b0;
    w_wdata = '0;
    w_wstrb = '0;
    case (commit_width)
      W_SB: begin
        w_legal = 1'b1;
        w_wdata = {4{commit_data[7:0]}};
        w_wstrb = 4'b0001 << commit_addr[1:0];
      end
      W_SH: begin
        w_legal = ~commit_addr[0];
        w_wdata = {2{commit_data[15:0]}};
        w_wstrb = commit_addr[1] ? 4'b1100 : 4'b0011;
      end
      W_SW: begin
        w_legal = (commit_addr[1:0] == 2'b00);
        w_wdata = commit_data;
        w_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  assign w_entry.addr_word = commit_addr[31:2];
  assign w_entry.wdata     = w_wdata;
  assign w_entry.wstrb     = w_wstrb;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_take & w_legal),
    .i_dat     (w_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_misalign_err <= w_take & ~w_legal;
    end
  end

  // Head only changes on pop, so the request fields stay stable while waiting for ack.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = REQ;
      end
      REQ: begin
        w_mem_req = 1'b1;
        if (mem_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  assign mem_req      = w_mem_req;
  assign mem_addr     = w_mem_req ? {w_head.addr_word, 2'b00} : 32'h0;
  assign mem_wdata    = w_mem_req ? w_head.wdata : 32'h0;
  assign mem_wstrb    = w_mem_req ? w_head.wstrb : 4'h0;
  assign misalign_err = r_misalign_err;
  assign count        = w_count;

`ifdef STORE_FWD_HAZARD_EN
  logic w_unused;
  logic w_hit;
  assign w_unused = &{1'b0, ld_addr[1:0]};

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].addr_word == ld_addr[31:2]) && (w_entries[i].wstrb != 4'h0))
        w_hit = 1'b1;
    end
  end

  assign ld_hit = w_hit;
`else
  logic w_unused;

  always_comb begin
    w_unused = ^{ld_addr, w_valid};
    for (int i = 0; i < DEPTH; i++) w_unused = w_unused ^ (^w_entries[i]);
  end

  assign ld_hit = ~w_empty;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench: reset, table vectors, directed corner sequences, then random traffic vs a queue model.
module tb_store_commit_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [2:0]  commit_width;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic        commit_ready;
  logic        misalign_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_width (commit_width),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .misalign_err (misalign_err),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit),
    .count        (count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  typedef struct {
    logic [2:0]  w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    bit          e_err;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  bit   busy;
  bit   exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] w, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    return (w == 3'd0) || (w == 3'd1 && off % 2 == 0) || (w == 3'd2 && off == 0);
  endfunction

  function automatic exp_t fmt(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   off;
    off    = int'(a % 4);
    e.addr = a - 32'(off);
    if (w == 3'd0) begin
      e.wdata = (d & 32'hFF) * 32'h0101_0101;
      e.wstrb = 4'(1 << off);
    end else if (w == 3'd1) begin
      e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
      e.wstrb = (off >= 2) ? 4'hC : 4'h3;
    end else begin
      e.wdata = d;
      e.wstrb = 4'hF;
    end
    return e;
  endfunction

  function automatic bit model_ld_hit(input logic [31:0] la);
`ifdef STORE_FWD_HAZARD_EN
    bit h;
    h = 1'b0;
    foreach (q[i]) if ((q[i].addr >> 2) == (la >> 2)) h = 1'b1;
    return h;
`else
    return q.size() != 0;
`endif
  endfunction

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("commit_ready", 32'(commit_ready), 32'(q.size() != DEPTH));
    chk("mem_req", 32'(mem_req), 32'(busy));
    if (busy) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wdata", mem_wdata, q[0].wdata);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].wstrb));
    end else begin
      chk("mem_addr_idle", mem_addr, 32'h0);
      chk("mem_wdata_idle", mem_wdata, 32'h0);
      chk("mem_wstrb_idle", 32'(mem_wstrb), 32'h0);
    end
    chk("misalign_err", 32'(misalign_err), 32'(exp_err));
    chk("ld_hit", 32'(ld_hit), 32'(model_ld_hit(ld_addr)));
  endtask

  // One clock edge: model advances with the pre-edge inputs, then outputs are compared.
  task automatic tick();
    bit nonempty;
    bit ack;
    bit take;
    bit ok;
    nonempty = (q.size() != 0);
    ack      = busy && mem_ack;
    take     = commit_valid && (q.size() != DEPTH);
    ok       = is_legal(commit_width, commit_addr);
    @(posedge clk);
    exp_err = take && !ok;
    if (ack) begin
      void'(q.pop_front());
      busy = 1'b0;
    end else if (!busy && nonempty) begin
      busy = 1'b1;
    end
    if (take && ok) q.push_back(fmt(commit_width, commit_addr, commit_data));
    #1;
    check_all();
  endtask

  task automatic drive(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    commit_valid = 1'b1;
    commit_width = w;
    commit_addr  = a;
    commit_data  = d;
  endtask

  task automatic drain();
    int guard;
    guard        = 0;
    commit_valid = 1'b0;
    mem_ack      = 1'b1;
    while (q.size() != 0 && guard < 4 * DEPTH + 4) begin
      tick();
      guard++;
    end
    mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  vec_t vt[9];

  initial begin
    vt[0] = '{3'd0, 32'h0000_1003, 32'hFFFF_FFAB, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 1'b0};
    vt[1] = '{3'd0, 32'h0000_1000, 32'h0000_0012, 32'h0000_1000, 32'h1212_1212, 4'b0001, 1'b0};
    vt[2] = '{3'd1, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 32'h1234_1234, 4'b1100, 1'b0};
    vt[3] = '{3'd1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011, 1'b0};
    vt[4] = '{3'd1, 32'h0000_2001, 32'h0000_1234, 32'h0,         32'h0,         4'b0000, 1'b1};
    vt[5] = '{3'd2, 32'h0000_4000, 32'hCAFE_F00D, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 1'b0};
    vt[6] = '{3'd2, 32'h0000_4002, 32'hCAFE_F00D, 32'h0,         32'h0,         4'b0000, 1'b1};
    vt[7] = '{3'd3, 32'h0000_5000, 32'h1111_2222, 32'h0,         32'h0,         4'b0000, 1'b1};
    vt[8] = '{3'd4, 32'h0000_5004, 32'h3333_4444, 32'h0,         32'h0,         4'b0000, 1'b1};

    reset        = 1'b1;
    commit_valid = 1'b0;
    commit_width = 3'd0;
    commit_addr  = 32'h0;
    commit_data  = 32'h0;
    mem_ack      = 1'b0;
    ld_addr      = 32'h0;
    busy         = 1'b0;
    exp_err      = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all();

    foreach (vt[i]) begin
      drive(vt[i].w, vt[i].addr, vt[i].data);
      tick();
      commit_valid = 1'b0;
      chk($sformatf("vec%0d_err", i), 32'(misalign_err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d_count", i), 32'(count), vt[i].e_err ? 32'd0 : 32'd1);
      tick();
      if (!vt[i].e_err) begin
        chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'd1);
        chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].e_wdata);
        chk($sformatf("vec%0d_wstrb", i), 32'(mem_wstrb), 32'(vt[i].e_wstrb));
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk($sformatf("vec%0d_drained", i), 32'(count), 32'd0);
    end

    for (int k = 0; k < 4; k++) begin
      drive(3'd2, 32'h100 + 32'(4 * k), 32'(k + 1));
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(commit_ready), 32'd0);
    drive(3'd2, 32'h200, 32'h99);
    tick();
    chk("full_reject", 32'(count), 32'd4);
    commit_valid = 1'b0;
    mem_ack      = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("after_ack_count", 32'(count), 32'd3);
    chk("after_ack_ready", 32'(commit_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("order%0d", k), mem_addr, 32'h100 + 32'(4 * k));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    chk("order_empty", 32'(count), 32'd0);

    drive(3'd2, 32'h600, 32'h5A5A_0001);
    tick();
    commit_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", mem_addr, 32'h600);
      chk("hold_wdata", mem_wdata, 32'h5A5A_0001);
      chk("hold_wstrb", 32'(mem_wstrb), 32'hF);
    end
    drive(3'd2, 32'h604, 32'h5A5A_0002);
    mem_ack = 1'b1;
    tick();
    commit_valid = 1'b0;
    mem_ack      = 1'b0;
    chk("push_pop_count", 32'(count), 32'd1);
    drain();

    drive(3'd2, 32'h3000, 32'h7777_8888);
    tick();
    commit_valid = 1'b0;
    ld_addr      = 32'h3002;
    #1;
    chk("ld_hit_same_word", 32'(ld_hit), 32'd1);
    ld_addr = 32'h3004;
    #1;
`ifdef STORE_FWD_HAZARD_EN
    chk("ld_hit_next_word", 32'(ld_hit), 32'd0);
`else
    chk("ld_hit_next_word", 32'(ld_hit), 32'd1);
`endif
    drain();

    for (int k = 0; k < 3; k++) begin
      drive(3'd2, 32'h700 + 32'(4 * k), 32'(k));
      tick();
    end
    commit_valid = 1'b0;
    chk("pre_reset_req", 32'(mem_req), 32'd1);
    #3;
    reset   = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    q.delete();
    busy    = 1'b0;
    exp_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_no_write", 32'(mem_req), 32'd0);
    end

    for (int n = 0; n < 2000; n++) begin
      int r;
      r            = int'($urandom_range(0, 9));
      commit_valid = ($urandom_range(0, 1) == 1);
      commit_width = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      commit_addr  = 32'h8000 + 32'($urandom_range(0, 31));
      commit_data  = $urandom;
      mem_ack      = ($urandom_range(0, 2) != 0);
      ld_addr      = 32'h8000 + 32'($urandom_range(0, 31));
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered committed stores; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 commit_valid  input  1  ROB presents a committed store this cycle.
REQ-005 commit_width  input  3  funct3 store width: 000 SB, 001 SH, 010 SW.
REQ-006 commit_addr  input  32  byte address, i.e. the addr field of the store result sent to the ROB.
REQ-007 commit_data  input  32  store data, low bytes significant; upper bits ignored.
REQ-008 commit_ready  output  1  buffer accepts a store this cycle.
REQ-009 misalign_err  output  1  one-cycle pulse when an accepted-handshake store is misaligned or has an illegal width.
REQ-010 mem_req  output  1  write request to data memory.
REQ-011 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-012 mem_wdata  output  32  lane-replicated write data.
REQ-013 mem_wstrb  output  4  byte enables.
REQ-014 mem_ack  input  1  memory accepted the current request.
REQ-015 ld_addr  input  32  load address for the hazard check.
REQ-016 ld_hit  output  1  a pending store overlaps ld_addr's word.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 A store SHALL be taken when commit_valid and commit_ready are both high; commit_ready SHALL equal (count != DEPTH), independent of mem_ack in the same cycle.
REQ-019 SB: mem_wdata = data[7:0] on all four lanes; mem_wstrb = 4'b0001 << addr[1:0].
REQ-020 SH: mem_wdata = data[15:0] on both halves; mem_wstrb = 0011 if addr[1]=0, else 1100; addr[0]=1 is misaligned.
REQ-021 SW: mem_wdata = data; mem_wstrb = 1111; addr[1:0] != 0 is misaligned.
REQ-022 Misaligned stores and widths other than 000/001/010 SHALL NOT be enqueued, and misalign_err SHALL pulse in the cycle after the handshake.
REQ-023 Stores SHALL drain in strict commit order.
REQ-024 FSM states: IDLE, REQ. IDLE->REQ when count != 0. In REQ, mem_req=1 and mem_addr/wdata/wstrb SHALL hold stable until mem_ack. REQ->IDLE on mem_ack, which pops the head in that same edge.
REQ-025 Latency: a store enqueued at edge N into an empty buffer SHALL produce mem_req high after edge N+1; maximum drain rate is one store per 2 cycles.
REQ-026 Simultaneous push and pop (not full) SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 mem_req SHALL be 0 in IDLE; mem_addr/wdata/wstrb SHALL be 0 when mem_req=0.

Reset
REQ-028 On reset: pointers=0, count=0, state=IDLE, mem_req=0, misalign_err=0, ld_hit=0, commit_ready=1.
REQ-029 Reset asserted mid-request SHALL drop mem_req immediately and discard all pending entries; a mem_ack arriving during reset SHALL be ignored.

Configuration
REQ-030 Macro STORE_FWD_HAZARD_EN: when defined, ld_hit SHALL be combinational = OR over valid entries of (entry word address == ld_addr[31:2] and entry wstrb != 0); when undefined, ld_hit SHALL be (count != 0) (conservative stall).

Structure
REQ-031 Package store_pkg SHALL hold width codes SB/SH/SW, the store_entry_t struct {addr_word[29:0], wdata[31:0], wstrb[3:0]}, and the state enum.
REQ-032 One sub-module, store_fifo (DEPTH x store_entry_t, with count/full/empty), SHALL hold the entry storage; lane formatting and the FSM SHALL live in the top.

Verification
REQ-033 SB addr=0x1003 data=0xFFFFFFAB -> mem_addr=0x1000, wdata=0xABABABAB, wstrb=1000; mem_ack -> count=0.
REQ-034 SH addr=0x2002 data=0x00001234 -> wdata=0x12341234, wstrb=1100; SH addr=0x2001 -> misalign_err pulse, count unchanged.
REQ-035 Push 4 SW with mem_ack=0 -> count=4, commit_ready=0; 5th valid is not taken; one ack -> count=3, ready=1; order preserved.
REQ-036 Hold mem_ack low for 5 cycles -> mem_req/addr/wdata/wstrb stable throughout; push and ack in the same cycle -> count unchanged.
REQ-037 With STORE_FWD_HAZARD_EN, pending SW at 0x3000: ld_addr=0x3002 -> ld_hit=1, ld_addr=0x3004 -> ld_hit=0; without the macro -> ld_hit=1 for both.
REQ-038 Assert reset during REQ with 3 entries pending -> mem_req=0 asynchronously, count=0, and no further writes after reset release.
